// File: rtl/guitar_pkg.sv
// Shared constants, note-word bit mapping and playback states
// for the guitar record/playback path.
package guitar_pkg;

    localparam int NUM_STRINGS = 6;
    localparam int NUM_FRETS   = 5;
    localparam int FRET_W      = 3;
    localparam int NOTE_BITS   = NUM_STRINGS * NUM_FRETS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_PRESENT,
        S_WAIT_BEAT,
        S_DONE
    } state_e;

    // Same mapping coordinates_converter uses when recording.
    function automatic int unsigned note_bit(
        input int unsigned f,
        input int unsigned s
    );
        return f * NUM_STRINGS + s;
    endfunction

endpackage

// File: rtl/note_playback_if.sv
// Decoded-note handshake from playback to the audio module.
// Master drives the note, slave returns ready.
interface note_playback_if;
    import guitar_pkg::*;

    logic                          note_valid;
    logic                          note_ready;
    logic [NUM_STRINGS-1:0]        string_active;
    logic [NUM_STRINGS*FRET_W-1:0] string_fret;

    modport master (
        output note_valid,
        output string_active,
        output string_fret,
        input  note_ready
    );

    modport slave (
        input  note_valid,
        input  string_active,
        input  string_fret,
        output note_ready
    );

endinterface

// File: rtl/note_decoder.sv
// Combinational note-word decoder: per-string highest fret,
// flags reserved bits or multiple frets on one string.
module note_decoder
    import guitar_pkg::*;
#(
    parameter int NOTE_W = 32
) (
    input  logic [NOTE_W-1:0]               word,
    output logic [NUM_STRINGS-1:0]          active,
    output logic [NUM_STRINGS*FRET_W-1:0]   fret,
    output logic                            malformed
);

    always_comb begin
        active    = '0;
        fret      = '0;
        malformed = |word[NOTE_W-1:NOTE_BITS];
        for (int s = 0; s < NUM_STRINGS; s++) begin
            // Ascending scan so the highest fret overwrites.
            for (int f = 0; f < NUM_FRETS; f++) begin
                if (word[note_bit(f, s)]) begin
                    if (active[s])
                        malformed = 1'b1;
                    active[s] = 1'b1;
                    fret[s*FRET_W +: FRET_W] = FRET_W'(f);
                end
            end
        end
    end

endmodule

// File: rtl/note_playback.sv
// Steps through the note RAM one word per beat and presents
// each decoded note to the audio module.
module note_playback
    import guitar_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int NOTE_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              beat,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [NOTE_W-1:0] mem_q,
    note_playback_if.master   note,
    output logic              playing,
    output logic              done,
    output logic              malformed,
    output logic              overrun
);

    localparam int SF_W = NUM_STRINGS * FRET_W;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                pending_q, pending_d;
    logic [NUM_STRINGS-1:0] active_q, active_d;
    logic [SF_W-1:0]     fret_q, fret_d;
    logic                malformed_q, malformed_d;
    logic                overrun_q, overrun_d;
    logic                note_valid_q, note_valid_d;
    logic                playing_q, playing_d;
    logic                done_q, done_d;

    logic [NUM_STRINGS-1:0] dec_active;
    logic [SF_W-1:0]        dec_fret;
    logic                   dec_malformed;
    logic                   last_note;

    note_decoder #(.NOTE_W(NOTE_W)) u_dec (
        .word      (mem_q),
        .active    (dec_active),
        .fret      (dec_fret),
        .malformed (dec_malformed)
    );

    // Compare as a count so a shrunk length still terminates.
    assign last_note = ({1'b0, mem_addr_q} + (ADDR_W+1)'(1))
                       >= length;

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        pending_d   = pending_q;
        active_d    = active_q;
        fret_d      = fret_q;
        malformed_d = malformed_q;
        overrun_d   = overrun_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    malformed_d = 1'b0;
                    overrun_d   = 1'b0;
                    mem_addr_d  = '0;
                    state_d     = (length == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:   state_d = S_CAPTURE;
            S_CAPTURE: begin
                active_d = dec_active;
                fret_d   = dec_fret;
                if (dec_malformed)
                    malformed_d = 1'b1;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (note.note_ready) begin
                    if (last_note) begin
                        state_d = S_DONE;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        state_d = (pending_q || beat) ? S_FETCH
                                                      : S_WAIT_BEAT;
                    end
                end
            end
            S_WAIT_BEAT: begin
                if (beat)
                    state_d = S_FETCH;
            end
            S_DONE: begin
                mem_addr_d = '0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (beat && (state_q == S_FETCH || state_q == S_CAPTURE ||
                     state_q == S_PRESENT)) begin
            if (pending_q)
                overrun_d = 1'b1;
            else
                pending_d = 1'b1;
        end

        if (state_d == S_FETCH)
            pending_d = 1'b0;

        // Abort: no done pulse, sticky flags untouched.
        if (stop) begin
            state_d     = S_IDLE;
            pending_d   = 1'b0;
            mem_addr_d  = '0;
            active_d    = active_q;
            fret_d      = fret_q;
            malformed_d = malformed_q;
            overrun_d   = overrun_q;
        end

        note_valid_d = (state_d == S_PRESENT);
        playing_d    = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_addr_q   <= '0;
            pending_q    <= 1'b0;
            active_q     <= '0;
            fret_q       <= '0;
            malformed_q  <= 1'b0;
            overrun_q    <= 1'b0;
            note_valid_q <= 1'b0;
            playing_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_addr_q   <= mem_addr_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            fret_q       <= fret_d;
            malformed_q  <= malformed_d;
            overrun_q    <= overrun_d;
            note_valid_q <= note_valid_d;
            playing_q    <= playing_d;
            done_q       <= done_d;
        end
    end

    assign mem_addr           = mem_addr_q;
    assign note.note_valid    = note_valid_q;
    assign note.string_active = active_q;
    assign note.string_fret   = fret_q;
    assign playing            = playing_q;
    assign done               = done_q;
    assign malformed          = malformed_q;
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_note_playback.sv
// Randomised and directed checks of note_playback against a
// transaction-level model of the note RAM contents.
module tb_note_playback;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, beat;
    logic [6:0]  length;
    logic [5:0]  mem_addr;
    logic [31:0] mem_q;
    logic        playing, done, malformed, overrun;
    logic [31:0] ram [64];

    int n_tests = 0;
    int n_fail  = 0;

    note_playback_if nif ();

    note_playback dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .beat     (beat),
        .length   (length),
        .mem_addr (mem_addr),
        .mem_q    (mem_q),
        .note     (nif.master),
        .playing  (playing),
        .done     (done),
        .malformed(malformed),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_q <= ram[mem_addr];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Decode rule: bit f*6+s means string s at fret f.
    function automatic void ref_decode(input logic [31:0] w,
                                       output logic [5:0] a,
                                       output logic [17:0] fr,
                                       output logic m);
        a  = '0;
        fr = '0;
        m  = (w >> 30) != 0;
        for (int s = 0; s < 6; s++) begin
            int n;
            int hi;
            n  = 0;
            hi = 0;
            for (int f = 0; f < 5; f++)
                if (((w >> (f * 6 + s)) & 1) != 0) begin
                    n++;
                    hi = f;
                end
            if (n > 0) begin
                a[s] = 1'b1;
                fr[s*3 +: 3] = hi[2:0];
            end
            if (n > 1) m = 1'b1;
        end
    endfunction

    function automatic logic [31:0] rand_word(input bit allow_bad);
        logic [31:0] w;
        w = '0;
        if (allow_bad && $urandom_range(0, 7) == 0)
            return $urandom;
        for (int s = 0; s < 6; s++) begin
            int f;
            f = $urandom_range(0, 5);
            if (f < 5) w = w | (32'd1 << (f * 6 + s));
        end
        return w;
    endfunction

    task automatic play(input int len, input int bper, input int smax);
        int idx, dones, bcnt, stall, cyc;
        logic [5:0]  ea;
        logic [17:0] ef;
        logic        em, mal_any;
        mal_any = 1'b0;
        for (int i = 0; i < len; i++) begin
            ref_decode(ram[i], ea, ef, em);
            mal_any |= em;
        end
        length = len[6:0];
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idx = 0; dones = 0; bcnt = 0; stall = -1; cyc = 0;
        while (dones == 0 && cyc < 4000) begin
            if (done) begin
                dones++;
            end else if (nif.note_valid) begin
                if (idx >= len) begin
                    chk("extra_note", 32'(idx), 32'(len));
                    idx = 0;
                end
                ref_decode(ram[idx], ea, ef, em);
                chk("play_addr", 32'(mem_addr), 32'(idx));
                chk("play_act", 32'(nif.string_active), 32'(ea));
                chk("play_fret", 32'(nif.string_fret), 32'(ef));
                if (stall < 0) stall = $urandom_range(0, smax);
                nif.note_ready = (stall == 0);
                if (stall == 0) begin
                    idx++;
                    stall = -1;
                end else begin
                    stall--;
                end
            end else begin
                nif.note_ready = 1'b0;
            end
            if (dones == 0) begin
                beat = (bcnt == bper - 1);
                bcnt = (bcnt + 1) % bper;
                cyc++;
                @(negedge clk);
            end
        end
        beat = 1'b0;
        nif.note_ready = 1'b0;
        chk("play_done_seen", 32'(dones), 32'd1);
        chk("play_count", 32'(idx), 32'(len));
        @(negedge clk);
        chk("play_idle", {30'd0, playing, done}, 32'd0);
        chk("play_malformed", 32'(malformed), 32'(mal_any));
        chk("play_overrun", 32'(overrun), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (!nif.note_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(nif.note_valid), 32'd1);
    endtask

    initial begin
        logic [5:0]  ea;
        logic [17:0] ef;
        logic        em;
        int          bad;
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; beat = 1'b0;
        length = '0;
        nif.note_ready = 1'b0;
        for (int i = 0; i < 64; i++) ram[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(nif.note_valid), 32'd0);
        chk("rst_flags", {28'd0, playing, done, malformed, overrun}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_note", {8'd0, nif.string_active, nif.string_fret}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Three single-string notes at frets 0,1,2.
        ram[0] = 32'h1; ram[1] = 32'h40; ram[2] = 32'h1000;
        play(3, 8, 0);

        // Three frets on string 0: highest wins.
        ram[0] = 32'h0000_1041;
        play(1, 8, 0);
        chk("multi_fret", 32'(nif.string_fret[2:0]), 32'd2);
        chk("multi_act", 32'(nif.string_active), 32'h01);
        chk("multi_mal", 32'(malformed), 32'd1);
        ram[0] = 32'hC000_0000;
        play(1, 8, 0);
        chk("rsv_act", 32'(nif.string_active), 32'd0);
        chk("rsv_mal", 32'(malformed), 32'd1);

        // Empty recording.
        length = '0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done", 32'(done), 32'd1);
        chk("len0_valid", 32'(nif.note_valid), 32'd0);
        @(negedge clk);
        chk("len0_end", {30'd0, done, nif.note_valid}, 32'd0);

        // Stall with two beats, then back-to-back note, then latency.
        for (int i = 0; i < 3; i++) ram[i] = rand_word(1'b0);
        length = 7'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("stall_first");
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            ref_decode(ram[0], ea, ef, em);
            if (!nif.note_valid || mem_addr != 6'd0 ||
                nif.string_active != ea || nif.string_fret != ef)
                bad++;
            beat = (i == 2 || i == 5);
            @(negedge clk);
        end
        beat = 1'b0;
        chk("stall_stable", 32'(bad), 32'd0);
        chk("stall_overrun", 32'(overrun), 32'd1);
        nif.note_ready = 1'b1;
        @(negedge clk);
        nif.note_ready = 1'b0;
        chk("pend_c1", 32'(nif.note_valid), 32'd0);
        @(negedge clk);
        chk("pend_c2", 32'(nif.note_valid), 32'd0);
        @(negedge clk);
        chk("pend_c3", 32'(nif.note_valid), 32'd1);
        chk("pend_addr", 32'(mem_addr), 32'd1);
        ref_decode(ram[1], ea, ef, em);
        chk("pend_note", 32'(nif.string_fret), 32'(ef));
        nif.note_ready = 1'b1;
        @(negedge clk);
        nif.note_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            if (nif.note_valid) bad++;
            @(negedge clk);
        end
        chk("wait_idle", 32'(bad), 32'd0);
        beat = 1'b1;
        @(negedge clk);
        beat = 1'b0;
        chk("lat_c1", 32'(nif.note_valid), 32'd0);
        @(negedge clk);
        chk("lat_c2", 32'(nif.note_valid), 32'd0);
        @(negedge clk);
        chk("lat_c3", 32'(nif.note_valid), 32'd1);
        chk("lat_addr", 32'(mem_addr), 32'd2);
        nif.note_ready = 1'b1;
        @(negedge clk);
        nif.note_ready = 1'b0;
        chk("stall_done", 32'(done), 32'd1);
        @(negedge clk);

        // Stop while presenting note 5 of 10.
        for (int i = 0; i < 10; i++) ram[i] = rand_word(1'b0);
        length = 7'd10;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 1;
        for (int c = 0; c < 1000 && bad != 0; c++) begin
            if (nif.note_valid && mem_addr == 6'd4) begin
                nif.note_ready = 1'b0;
                stop = 1'b1;
                bad  = 0;
            end else begin
                nif.note_ready = nif.note_valid;
                beat = (c % 12 == 11);
            end
            @(negedge clk);
        end
        beat = 1'b0;
        stop = 1'b0;
        chk("stop_reached", 32'(bad), 32'd0);
        chk("stop_state", {29'd0, playing, nif.note_valid, done}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            if (done || playing) bad++;
        end
        chk("stop_quiet", 32'(bad), 32'd0);
        play(4, 12, 2);

        // Random recordings, including full depth.
        for (int r = 0; r < 6; r++) begin
            int len;
            len = (r == 0) ? 64 : $urandom_range(1, 40);
            for (int i = 0; i < 64; i++) ram[i] = rand_word(1'b1);
            play(len, 12, 3);
        end

        // Asynchronous reset while waiting for a beat.
        ram[0] = 32'h0000_1041; ram[1] = 32'h2; ram[2] = 32'h4;
        length = 7'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("arst_first");
        nif.note_ready = 1'b1;
        @(negedge clk);
        nif.note_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_pre", {29'd0, playing, malformed, nif.string_active[0]},
            32'd7);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_flags", {28'd0, playing, done, malformed, overrun}, 32'd0);
        chk("arst_valid", 32'(nif.note_valid), 32'd0);
        chk("arst_addr", 32'(mem_addr), 32'd0);
        chk("arst_note", {8'd0, nif.string_active, nif.string_fret}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
